// File: rtl/vga_scan_gen.sv
// vga_scan_gen: VGA timing and frame-buffer read addressing with pixel replication and latency-matched sync/enable
module vga_scan_gen #(
  parameter int H_ACTIVE    = 640,
  parameter int H_FP        = 16,
  parameter int H_SYNC      = 96,
  parameter int H_BP        = 48,
  parameter int V_ACTIVE    = 480,
  parameter int V_FP        = 10,
  parameter int V_SYNC      = 2,
  parameter int V_BP        = 33,
  parameter int IMG_W       = 160,
  parameter int IMG_H       = 120,
  parameter int SCALE_SHIFT = 2,
  parameter int RD_LAT      = 2,
  parameter int ADDR_W      = 15
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              BANK_IN,
  output logic              HSYNC,
  output logic              VSYNC,
  output logic              enable,
  output logic              RD_EN,
  output logic [ADDR_W:0]   ADDR,
  output logic              FRAME_START
);
  localparam int H_TOT = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOT = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HW = $clog2(H_TOT);
  localparam int VW = $clog2(V_TOT);
  logic [HW-1:0] h;
  logic [VW-1:0] v;
  logic bank_q, h_end, v_end, fs, hs_raw, vs_raw, win;
  logic [ADDR_W-1:0] idx;
  logic [2:0] sr [RD_LAT];
  // raw timing decode; reset masks the read side so nothing is fetched while held
  always_comb begin
    h_end = h == HW'(H_TOT - 1);
    v_end = v == VW'(V_TOT - 1);
    fs = !reset && h == '0 && v == '0;
    hs_raw = !(h >= HW'(H_ACTIVE + H_FP) && h < HW'(H_ACTIVE + H_FP + H_SYNC));
    vs_raw = !(v >= VW'(V_ACTIVE + V_FP) && v < VW'(V_ACTIVE + V_FP + V_SYNC));
    win = !reset && h < HW'(IMG_W << SCALE_SHIFT) && v < VW'(IMG_H << SCALE_SHIFT);
    idx = ADDR_W'(32'(v >> SCALE_SHIFT) * IMG_W + 32'(h >> SCALE_SHIFT));
  end
  // bank is taken straight from BANK_IN on the frame-start cycle so the first pixel already uses it
  assign RD_EN = win;
  assign FRAME_START = fs;
  assign ADDR = win ? {fs ? BANK_IN : bank_q, idx} : '0;
  assign {HSYNC, VSYNC, enable} = sr[RD_LAT-1];
  // pixel/line counters and per-frame bank latch
  always_ff @(posedge clk) begin
    if (reset) begin
      h <= '0;
      v <= '0;
      bank_q <= 1'b0;
    end else begin
      h <= h_end ? '0 : h + 1'b1;
      v <= h_end ? (v_end ? '0 : v + 1'b1) : v;
      if (fs) bank_q <= BANK_IN;
    end
  end
  // delay line matching sync/enable to the frame-buffer read latency; cleared to inactive levels
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < RD_LAT; i++) sr[i] <= 3'b110;
    end else begin
      sr[0] <= {hs_raw, vs_raw, win};
      for (int i = 1; i < RD_LAT; i++) sr[i] <= sr[i-1];
    end
  end
endmodule
